// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the single-clock true dual-port byte-enable RAM.
// Read-during-write mode encodings, clear FSM states and the byte-lane merge function.
package tdp_ram_pkg;

  localparam int RD_FIRST  = 0;
  localparam int WR_FIRST  = 1;
  localparam int NO_CHANGE = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_DW = 1024;
  typedef logic [MAX_DW-1:0] wide_t;

  function automatic wide_t byte_merge(wide_t old_w, wide_t new_w, wide_t be, int bw);
    wide_t res;
    res = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      if (be[i / bw]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// One RAM port's read path: read-mode mux, VALID generation and optional output stage.
// A write in NO_CHANGE mode leaves DOUT untouched and raises no VALID.
module tdp_ram_port
  import tdp_ram_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int BWIDTH  = 8,
  parameter int RD_MODE = RD_FIRST,
  parameter int OUT_REG = 0,
  localparam int NB     = DWIDTH / BWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready_i,
  input  logic              en_i,
  input  logic [NB-1:0]     we_i,
  input  logic [DWIDTH-1:0] din_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic [DWIDTH-1:0] dout_o,
  output logic              valid_o
);

  logic              access;
  logic              wr;
  logic [DWIDTH-1:0] merged;
  logic [DWIDTH-1:0] dout_d, dout1_q;
  logic              valid_d, valid1_q;

  assign access = ready_i & en_i;
  assign wr     = access & (|we_i);
  assign merged = DWIDTH'(byte_merge(wide_t'(rd_data_i), wide_t'(din_i), wide_t'(we_i), BWIDTH));

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
    dout_d  = dout1_q;
    valid_d = 1'b0;
    if (access) begin
      if (!wr) begin
        dout_d  = rd_data_i;
        valid_d = 1'b1;
      end else if (RD_MODE == WR_FIRST) begin
        dout_d  = merged;
        valid_d = 1'b1;
      end else if (RD_MODE == RD_FIRST) begin
        dout_d  = rd_data_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      dout1_q  <= dout_d;
      valid1_q <= valid_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DWIDTH-1:0] dout2_q;
    logic              valid2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        dout2_q  <= dout1_q;
        valid2_q <= valid1_q;
      end
    end

    assign dout_o  = dout2_q;
    assign valid_o = valid2_q;
  end else begin : g_out_direct
    assign dout_o  = dout1_q;
    assign valid_o = valid1_q;
  end

endmodule

// File: rtl/tdp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, reset-driven clear and A-priority arbitration.
// Define TDP_RAM_COLL_DET_EN to add the COLL / COLL_CNT same-address collision monitor.
module tdp_ram_be
  import tdp_ram_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int BWIDTH  = 8,
  parameter int RD_MODE = RD_FIRST,
  parameter int OUT_REG = 0,
  localparam int NB     = DWIDTH / BWIDTH,
  localparam int DEPTH  = 2 ** AWIDTH
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef TDP_RAM_COLL_DET_EN
  output logic              COLL,
  output logic [15:0]       COLL_CNT,
`endif
  output logic              INIT_DONE,
  input  logic              ENA,
  input  logic [NB-1:0]     WEA,
  input  logic [AWIDTH-1:0] ADDRA,
  input  logic [DWIDTH-1:0] DINA,
  output logic [DWIDTH-1:0] DOUTA,
  output logic              VALIDA,
  input  logic              ENB,
  input  logic [NB-1:0]     WEB,
  input  logic [AWIDTH-1:0] ADDRB,
  input  logic [DWIDTH-1:0] DINB,
  output logic [DWIDTH-1:0] DOUTB,
  output logic              VALIDB
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_e            state_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              init_done_q;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_a, wr_b, same_addr;
  logic [DWIDTH-1:0] rd_a, rd_b;
  logic [DWIDTH-1:0] word_a, word_b, base_a;

  assign ready     = (state_q == READY);
  assign rd_a      = mem[ADDRA];
  assign rd_b      = mem[ADDRB];
  assign wr_a      = ready & ENA & (|WEA);
  assign wr_b      = ready & ENB & (|WEB);
  assign same_addr = (ADDRA == ADDRB);

  // On a shared address, A's lanes are merged over B's result so A wins only where both write.
  assign word_b = DWIDTH'(byte_merge(wide_t'(rd_b), wide_t'(DINB), wide_t'(WEB), BWIDTH));
  assign base_a = (wr_b && same_addr) ? word_b : rd_a;
  assign word_a = DWIDTH'(byte_merge(wide_t'(base_a), wide_t'(DINA), wide_t'(WEA), BWIDTH));

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset term; the clear FSM zeroes it, which keeps it RAM-mappable.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == CLEAR) begin
        mem[cnt_q] <= '0;
      end else begin
        if (wr_a) mem[ADDRA] <= word_a;
        if (wr_b && !(wr_a && same_addr)) mem[ADDRB] <= word_b;
      end
    end
  end

  assign INIT_DONE = init_done_q;

  tdp_ram_port #(
    .DWIDTH (DWIDTH),
    .BWIDTH (BWIDTH),
    .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG)
  ) u_port_a (
    .clk      (CLK),
    .rst      (RST),
    .ready_i  (ready),
    .en_i     (ENA),
    .we_i     (WEA),
    .din_i    (DINA),
    .rd_data_i(rd_a),
    .dout_o   (DOUTA),
    .valid_o  (VALIDA)
  );

  tdp_ram_port #(
    .DWIDTH (DWIDTH),
    .BWIDTH (BWIDTH),
    .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG)
  ) u_port_b (
    .clk      (CLK),
    .rst      (RST),
    .ready_i  (ready),
    .en_i     (ENB),
    .we_i     (WEB),
    .din_i    (DINB),
    .rd_data_i(rd_b),
    .dout_o   (DOUTB),
    .valid_o  (VALIDB)
  );

`ifdef TDP_RAM_COLL_DET_EN
  logic        coll_d, coll_q;
  logic [15:0] coll_cnt_q;

  assign coll_d = ready & ENA & ENB & same_addr & ((|WEA) | (|WEB));

  always_ff @(posedge CLK) begin
    if (RST) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q <= coll_d;
      if (coll_d && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
    end
  end

  assign COLL     = coll_q;
  assign COLL_CNT = coll_cnt_q;
`endif

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: four instances covering the read-modes and output-register options,
// checked every cycle against a word/lane-level memory model plus hand-computed literals.
module tb_tdp_ram_be;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENA = 1'b0, ENB = 1'b0;
  logic [3:0]  WEA = '0, WEB = '0;
  logic [4:0]  ADDRA = '0, ADDRB = '0;
  logic [31:0] DINA = '0, DINB = '0;

  logic [31:0] douta [4];
  logic [31:0] doutb [4];
  logic        valida [4];
  logic        validb [4];
  logic        init_done [4];
`ifdef TDP_RAM_COLL_DET_EN
  logic        coll [4];
  logic [15:0] coll_cnt [4];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // g0: read-first, g1: write-first + out reg, g2: no-change, g3: read-first + out reg
  for (genvar g = 0; g < 4; g++) begin : g_dut
    tdp_ram_be #(
      .DWIDTH (32),
      .AWIDTH (5),
      .BWIDTH (8),
      .RD_MODE((g == 3) ? 0 : g),
      .OUT_REG((g == 1 || g == 3) ? 1 : 0)
    ) u_dut (
      .CLK      (CLK),
      .RST      (RST),
`ifdef TDP_RAM_COLL_DET_EN
      .COLL     (coll[g]),
      .COLL_CNT (coll_cnt[g]),
`endif
      .INIT_DONE(init_done[g]),
      .ENA      (ENA),
      .WEA      (WEA),
      .ADDRA    (ADDRA),
      .DINA     (DINA),
      .DOUTA    (douta[g]),
      .VALIDA   (valida[g]),
      .ENB      (ENB),
      .WEB      (WEB),
      .ADDRB    (ADDRB),
      .DINB     (DINB),
      .DOUTB    (doutb[g]),
      .VALIDB   (validb[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int mode_of(int g);
    return (g == 3) ? 0 : g;
  endfunction

  function automatic bit oreg_of(int g);
    return (g == 1 || g == 3);
  endfunction

  function automatic logic [31:0] lane_mix(logic [31:0] old_w, logic [31:0] din, logic [3:0] we);
    for (int l = 0; l < 4; l++) begin
      if (we[l]) old_w[8*l +: 8] = din[8*l +: 8];
    end
    return old_w;
  endfunction

  // Reference model: memory contents, each port's latest result and the result before it.
  logic [31:0] m_mem [32];
  bit          m_started = 1'b0;
  bit          m_ready, m_init, m_coll;
  int          m_cnt, m_ccnt;
  logic [31:0] cur_d  [4][2];
  logic [31:0] prev_d [4][2];
  bit          cur_v  [4][2];
  bit          prev_v [4][2];

  always @(posedge CLK) begin : model
    logic [31:0] rd [2];
    logic [31:0] din [2];
    logic [3:0]  we [2];
    bit          en [2];
    bit          wr [2];
    en[0] = ENA;  we[0] = WEA;  din[0] = DINA;
    en[1] = ENB;  we[1] = WEB;  din[1] = DINB;
    wr[0] = ENA && (WEA != 0);
    wr[1] = ENB && (WEB != 0);
    if (RST) begin
      m_started = 1'b1;
      m_ready = 1'b0;  m_init = 1'b0;  m_coll = 1'b0;
      m_cnt = 0;  m_ccnt = 0;
      for (int g = 0; g < 4; g++) begin
        for (int p = 0; p < 2; p++) begin
          cur_d[g][p] = '0;  prev_d[g][p] = '0;
          cur_v[g][p] = 1'b0;  prev_v[g][p] = 1'b0;
        end
      end
    end else begin
      if (m_ready) begin
        rd[0] = m_mem[ADDRA];
        rd[1] = m_mem[ADDRB];
      end else begin
        rd[0] = '0;
        rd[1] = '0;
      end
      for (int g = 0; g < 4; g++) begin
        for (int p = 0; p < 2; p++) begin
          prev_d[g][p] = cur_d[g][p];
          prev_v[g][p] = cur_v[g][p];
          cur_v[g][p]  = 1'b0;
          if (m_ready && en[p]) begin
            if (!wr[p] || mode_of(g) == 0) begin
              cur_d[g][p] = rd[p];
              cur_v[g][p] = 1'b1;
            end else if (mode_of(g) == 1) begin
              cur_d[g][p] = lane_mix(rd[p], din[p], we[p]);
              cur_v[g][p] = 1'b1;
            end
          end
        end
      end
      if (!m_ready) begin
        m_coll = 1'b0;
        m_mem[m_cnt] = '0;
        if (m_cnt == 31) begin
          m_ready = 1'b1;
          m_init  = 1'b1;
        end else begin
          m_cnt++;
        end
      end else begin
        m_coll = ENA && ENB && (ADDRA == ADDRB) && (wr[0] || wr[1]);
        if (m_coll && m_ccnt < 65535) m_ccnt++;
        if (wr[1]) m_mem[ADDRB] = lane_mix(m_mem[ADDRB], DINB, WEB);
        if (wr[0]) m_mem[ADDRA] = lane_mix(m_mem[ADDRA], DINA, WEA);
      end
    end
  end

  always @(negedge CLK) begin : compare
    if (m_started) begin
      for (int g = 0; g < 4; g++) begin
        check($sformatf("g%0d init_done", g), init_done[g], m_init);
        check($sformatf("g%0d douta", g), douta[g], oreg_of(g) ? prev_d[g][0] : cur_d[g][0]);
        check($sformatf("g%0d valida", g), valida[g], oreg_of(g) ? prev_v[g][0] : cur_v[g][0]);
        check($sformatf("g%0d doutb", g), doutb[g], oreg_of(g) ? prev_d[g][1] : cur_d[g][1]);
        check($sformatf("g%0d validb", g), validb[g], oreg_of(g) ? prev_v[g][1] : cur_v[g][1]);
`ifdef TDP_RAM_COLL_DET_EN
        check($sformatf("g%0d coll", g), coll[g], m_coll);
        check($sformatf("g%0d coll_cnt", g), coll_cnt[g], m_ccnt[15:0]);
`endif
      end
    end
  end

  task automatic op(input bit ea, input logic [3:0] wa, input logic [4:0] aa, input logic [31:0] da,
                    input bit eb, input logic [3:0] wb, input logic [4:0] ab, input logic [31:0] db);
    ENA = ea;  WEA = wa;  ADDRA = aa;  DINA = da;
    ENB = eb;  WEB = wb;  ADDRB = ab;  DINB = db;
    @(negedge CLK);
  endtask

  task automatic idle();
    op(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
  endtask

  initial begin : driver
    int n;
    int a;

    // Reset, then clear latency
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst douta", douta[0], 32'h0);
    check("rst valida", valida[0], 32'h0);
    check("rst init_done", init_done[0], 32'h0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!init_done[0] && n < 40);
    check("init latency", n, 32);

    // Every address reads zero after the clear
    for (a = 0; a < 32; a++) begin
      op(1'b1, 4'h0, a[4:0], 32'h0, 1'b1, 4'h0, 5'(31 - a), 32'h0);
      check("clear rd a", douta[0], 32'h0);
      check("clear rd b", doutb[0], 32'h0);
      check("clear valid a", valida[0], 32'h1);
    end

    // Byte-lane write, then read latency on both output-register settings
    op(1'b1, 4'hF, 5'd5, 32'h11223344, 1'b0, 4'h0, 5'd0, 32'h0);
    op(1'b1, 4'b0101, 5'd5, 32'hAABBCCDD, 1'b0, 4'h0, 5'd0, 32'h0);
    op(1'b1, 4'h0, 5'd5, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
    check("byte rd lat1", douta[0], 32'h11BB33DD);
    check("byte valid lat1", valida[0], 32'h1);
    idle();
    check("byte rd lat2", douta[3], 32'h11BB33DD);
    check("byte valid lat2", valida[3], 32'h1);
    check("valid pulse", valida[0], 32'h0);

    // Same-port read-during-write in all three modes
    op(1'b1, 4'h0, 5'd5, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
    op(1'b1, 4'hF, 5'd3, 32'hFFFFFFFF, 1'b0, 4'h0, 5'd0, 32'h0);
    check("rd_first dout", douta[0], 32'h0);
    check("rd_first valid", valida[0], 32'h1);
    check("no_change dout", douta[2], 32'h11BB33DD);
    check("no_change valid", valida[2], 32'h0);
    idle();
    check("wr_first dout", douta[1], 32'hFFFFFFFF);
    check("wr_first valid", valida[1], 32'h1);
    check("rd_first oreg dout", douta[3], 32'h0);

    // Both ports write address 7: A wins
    op(1'b1, 4'hF, 5'd7, 32'h1, 1'b1, 4'hF, 5'd7, 32'h2);
`ifdef TDP_RAM_COLL_DET_EN
    check("coll pulse", coll[0], 32'h1);
    check("coll cnt 1", coll_cnt[0], 32'h1);
`endif
    op(1'b1, 4'h0, 5'd7, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
    check("ww arb", douta[0], 32'h1);

    // Split and overlapping lanes on a shared address
    op(1'b1, 4'b0011, 5'd9, 32'h11111111, 1'b1, 4'b1100, 5'd9, 32'h22222222);
    op(1'b1, 4'h0, 5'd9, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
    check("split lanes", douta[0], 32'h22221111);
    op(1'b1, 4'b0110, 5'd10, 32'hAAAAAAAA, 1'b1, 4'b0011, 5'd10, 32'hBBBBBBBB);
    op(1'b1, 4'h0, 5'd10, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
    check("overlap lanes", douta[0], 32'h00AAAABB);

    // Cross-port read of a word being written returns the old word
    op(1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b1, 4'h0, 5'd5, 32'h0);
    check("cross rd old", doutb[0], 32'h11BB33DD);
`ifdef TDP_RAM_COLL_DET_EN
    check("coll cnt 4", coll_cnt[0], 32'h4);
`endif
    op(1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 4'h0, 5'd5, 32'h0);
    check("cross rd new", doutb[0], 32'hDEADBEEF);

    // Reset reasserted part way through a clear; accesses during clear are ignored
    RST = 1'b1;
    idle();
    RST = 1'b0;
    repeat (10) op(1'b1, 4'hF, 5'd0, 32'h12345678, 1'b1, 4'h0, 5'd0, 32'h0);
    check("midclear init", init_done[0], 32'h0);
    RST = 1'b1;
    idle();
    RST = 1'b0;
    n = 0;
    do begin
      op(1'b1, 4'hF, 5'd0, 32'h12345678, 1'b1, 4'hF, 5'd1, 32'h0F0F0F0F);
      n++;
    end while (!init_done[0] && n < 40);
    check("reclear latency", n, 32);
    op(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 4'h0, 5'd1, 32'h0);
    check("reclear rd a", douta[0], 32'h0);
    check("reclear rd b", doutb[0], 32'h0);
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tdp_ram_be.md
Name: tdp_ram_be

Overview:
- Parametrised single-clock true dual-port RAM; successor to the team's two-clock dual-port RAM.
- Adds byte-lane write enables, a selectable read-during-write mode and an optional output pipeline register.
- Adds a reset-driven memory-clear state machine and deterministic same-address write arbitration.
- Used as generic scratch/buffer storage shared by two masters in one clock domain.

Parameters:
- DWIDTH, 32: data width; must be a multiple of BWIDTH.
- AWIDTH, 5: address width; depth = 2**AWIDTH.
- BWIDTH, 8: byte-lane width; NB = DWIDTH/BWIDTH lanes.
- RD_MODE, 0: same-port read-during-write. 0 = read-first (old data), 1 = write-first (merged new data), 2 = no-change (DOUT holds).
- OUT_REG, 0: 1 adds an output pipeline stage.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INIT_DONE  out  1  high once the memory clear has completed.
- ENA  in  1  port A enable.
- WEA  in  NB  port A byte write enables.
- ADDRA  in  AWIDTH  port A address.
- DINA  in  DWIDTH  port A write data.
- DOUTA  out  DWIDTH  port A read data.
- VALIDA  out  1  DOUTA updated this cycle (read issued).
- ENB, WEB, ADDRB, DINB, DOUTB, VALIDB: same as port A, for port B.

Behaviour:
- Reset
  - RST sampled high: DOUTA, DOUTB, pipeline registers = 0; VALIDA, VALIDB, INIT_DONE = 0; FSM enters CLEAR; clear counter = 0.
- FSM states
  - CLEAR: writes 0 to mem[cnt] each cycle, cnt += 1. At cnt == DEPTH-1 the write occurs, then the FSM goes to READY; INIT_DONE = 1 from the next cycle. CLEAR lasts exactly DEPTH cycles after RST deasserts.
  - READY: normal operation; stays until RST.
  - RST asserted in either state: restart CLEAR at address 0; memory content is undefined until the clear completes.
- Port behaviour in CLEAR: ENA/ENB ignored; no writes; VALIDx = 0; DOUTx hold 0.
- Access per port (READY, ENx = 1)
  - WEx == 0: read.
  - WEx != 0: write; only lanes with WEx[i] = 1 are updated.
  - ENx = 0: no access; DOUTx holds; VALIDx = 0.
- Read latency
  - OUT_REG = 0: DOUTx/VALIDx update 1 cycle after the request.
  - OUT_REG = 1: 2 cycles.
  - VALIDx is a 1-cycle pulse aligned with DOUTx.
- Same-port write with RD_MODE:
  - 0: DOUTx = old word; VALIDx = 1.
  - 1: DOUTx = old word with enabled lanes replaced by DINx; VALIDx = 1.
  - 2: DOUTx holds; VALIDx = 0.
- Cross-port read of an address the other port writes in the same cycle: the reader gets old data.
- Both ports write the same address in the same cycle:
  - Lanes enabled on both ports take port A's data.
  - Lanes enabled on one port only take that port's data.
- Pipeline: the OUT_REG stage is reset by RST; no stall input, so one result per cycle per port.

Optional Feature:
- Macro: TDP_RAM_COLL_DET_EN.
- When defined:
  - Adds outputs COLL (1) and COLL_CNT (16).
  - COLL pulses 1 cycle after any same-address access pair in READY where at least one port writes (write/write or read/write).
  - COLL_CNT increments on each such event and saturates at 0xFFFF.
  - Both are cleared by RST.
- When undefined: ports absent; arbitration and read results are identical.

Decomposition:
- Package tdp_ram_pkg holds:
  - RD_MODE encodings RD_FIRST = 0, WR_FIRST = 1, NO_CHANGE = 2.
  - FSM state typedef {CLEAR, READY}.
  - Function computing the byte-merged word from old data, new data and enables.
- Sub-module tdp_ram_port: one instance per port. It holds the read-mode mux, the optional output register and VALID generation.
- Top holds the storage array, clear FSM, arbitration and collision logic.

Test Plan:
- Clear: RST for 1 cycle, DEPTH = 32 → INIT_DONE rises exactly 32 cycles after RST falls; then reading every address gives 0.
- Byte write: A writes 0xAABBCCDD to 5 with WEA = 4'b0101 over 0x11223344 → A reads 0x11BB33DD; VALIDA 1 cycle later (OUT_REG = 0) or 2 cycles later (OUT_REG = 1).
- RD_MODE: old mem[3] = 0x0, A writes 0xFFFFFFFF, WEA = 4'hF → DOUTA = 0x0 (mode 0), 0xFFFFFFFF (mode 1), unchanged with VALIDA = 0 (mode 2).
- Collision: A writes 0x1 and B writes 0x2 to addr 7 with full enables → mem[7] = 0x1; COLL = 1, COLL_CNT = 1 when TDP_RAM_COLL_DET_EN is defined.
- Split lanes: same address, WEA = 4'b0011, WEB = 4'b1100, DINA = 0x11111111, DINB = 0x22222222 → 0x22221111.
- Reset mid-clear: RST reasserted at clear count 10 → INIT_DONE stays 0; a full 32-cycle clear restarts; accesses during CLEAR are ignored.
